intersection_select_seq: RTL and testbench

// Downstream stage of the two-circle intersection block in the trilateration datapath.

---
 rtl/intersection_select_seq.sv | 199 +++++++++++++++++++
 tb/tb_intersection_select_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/intersection_select_seq.sv
// Picks whichever of two intersection candidates lies closest to anchor circle A, using one shared squarer over 5 cycles.
// Define SELECT_ERR_EN to add the err_min port, which carries the residual of the chosen candidate.
module intersection_select_seq #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [14*N+33:0]      cand,
    input  logic [3*N:0]          a_init,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic signed [4*N+9:0] x_sel,
    output logic signed [3*N+6:0] y_sel,
    output logic                  sel,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SELECT_ERR_EN
    ,
    output logic [8*N+23:0]       err_min
`endif
);
    localparam int XW  = 4*N+10;
    localparam int YW  = 3*N+7;
    localparam int RW  = N+1;
    localparam int CW  = 14*N+34;
    localparam int AIW = 3*N+1;
    localparam int DW  = 4*N+11;
    localparam int DYW = 3*N+8;
    localparam int PW  = 2*DW;
    localparam int AW  = 8*N+23;
    localparam int SW  = 2*N+2;
    localparam int EW  = 8*N+24;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP, S_OUT} state_t;

    state_t                state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic [CW-1:0]         cand_q, cand_d;
    logic [AIW-1:0]        a_q, a_d;
    logic signed [AW-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
    logic signed [SW-1:0]  rsq_q, rsq_d;
    logic signed [XW-1:0]  x_sel_q, x_sel_d;
    logic signed [YW-1:0]  y_sel_q, y_sel_d;
    logic                  sel_q, sel_d;
`ifdef SELECT_ERR_EN
    logic [EW-1:0]         err_q, err_d;
`endif

    logic signed [XW-1:0]  x1, x2;
    logic signed [YW-1:0]  y1, y2;
    logic signed [N-1:0]   xa, ya;
    logic signed [RW-1:0]  ra;
    logic signed [DW-1:0]  dx1, dx2, mul_op;
    logic signed [DYW-1:0] dy1, dy2;
    logic signed [PW-1:0]  mul_ext, prod;
    logic signed [AW-1:0]  prod_acc;
    logic signed [EW-1:0]  e1, e2;
    logic [EW-1:0]         res1, res2;

    function automatic logic [EW-1:0] abs_res(input logic signed [EW-1:0] e);
        return e[EW-1] ? -e : e;
    endfunction

    // Operand unpacking and differences, sign-extended so nothing can overflow.
    always_comb begin
        x1 = cand_q[CW-1 -: XW];
        y1 = cand_q[XW+2*YW-1 -: YW];
        x2 = cand_q[XW+YW-1 -: XW];
        y2 = cand_q[YW-1:0];
        xa = a_q[AIW-1 -: N];
        ya = a_q[2*N:N+1];
        ra = a_q[RW-1:0];
        dx1 = {{(DW-XW){x1[XW-1]}}, x1} - {{(DW-N){xa[N-1]}}, xa};
        dx2 = {{(DW-XW){x2[XW-1]}}, x2} - {{(DW-N){xa[N-1]}}, xa};
        dy1 = {{(DYW-YW){y1[YW-1]}}, y1} - {{(DYW-N){ya[N-1]}}, ya};
        dy2 = {{(DYW-YW){y2[YW-1]}}, y2} - {{(DYW-N){ya[N-1]}}, ya};
        case (step_q)
            3'd0:    mul_op = dx1;
            3'd1:    mul_op = {{(DW-DYW){dy1[DYW-1]}}, dy1};
            3'd2:    mul_op = dx2;
            3'd3:    mul_op = {{(DW-DYW){dy2[DYW-1]}}, dy2};
            default: mul_op = {{(DW-RW){ra[RW-1]}}, ra};
        endcase
        mul_ext  = {{DW{mul_op[DW-1]}}, mul_op};
        prod     = mul_ext * mul_ext;
        prod_acc = {{(AW-PW){prod[PW-1]}}, prod};
        e1   = {{(EW-AW){acc1_q[AW-1]}}, acc1_q} - {{(EW-SW){rsq_q[SW-1]}}, rsq_q};
        e2   = {{(EW-AW){acc2_q[AW-1]}}, acc2_q} - {{(EW-SW){rsq_q[SW-1]}}, rsq_q};
        res1 = abs_res(e1);
        res2 = abs_res(e2);
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cand_d  = cand_q;
        a_d     = a_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        rsq_d   = rsq_q;
        x_sel_d = x_sel_q;
        y_sel_d = y_sel_q;
        sel_d   = sel_q;
`ifdef SELECT_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cand_d  = cand;
                    a_d     = a_init;
                    acc1_d  = '0;
                    acc2_d  = '0;
                    rsq_d   = '0;
                    step_d  = 3'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                step_d = step_q + 3'd1;
                case (step_q)
                    3'd0:    acc1_d = prod_acc;
                    3'd1:    acc1_d = acc1_q + prod_acc;
                    3'd2:    acc2_d = prod_acc;
                    3'd3:    acc2_d = acc2_q + prod_acc;
                    default: begin
                        rsq_d   = prod[SW-1:0];
                        step_d  = 3'd0;
                        state_d = S_CMP;
                    end
                endcase
            end
            S_CMP: begin
                // Ties resolve to candidate 1.
                if (res1 <= res2) begin
                    x_sel_d = x1;
                    y_sel_d = y1;
                    sel_d   = 1'b0;
`ifdef SELECT_ERR_EN
                    err_d   = res1;
`endif
                end else begin
                    x_sel_d = x2;
                    y_sel_d = y2;
                    sel_d   = 1'b1;
`ifdef SELECT_ERR_EN
                    err_d   = res2;
`endif
                end
                state_d = S_OUT;
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cand_q  <= '0;
            a_q     <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            rsq_q   <= '0;
            x_sel_q <= '0;
            y_sel_q <= '0;
            sel_q   <= 1'b0;
`ifdef SELECT_ERR_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cand_q  <= cand_d;
            a_q     <= a_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            rsq_q   <= rsq_d;
            x_sel_q <= x_sel_d;
            y_sel_q <= y_sel_d;
            sel_q   <= sel_d;
`ifdef SELECT_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign x_sel     = x_sel_q;
    assign y_sel     = y_sel_q;
    assign sel       = sel_q;
`ifdef SELECT_ERR_EN
    assign err_min   = err_q;
`endif

endmodule

// File: tb/tb_intersection_select_seq.sv
// Bench for intersection_select_seq: directed cases plus randomized jobs against a wide-integer distance model.
module tb_intersection_select_seq;
    localparam int N   = 8;
    localparam int XW  = 4*N+10;
    localparam int YW  = 3*N+7;
    localparam int CW  = 14*N+34;
    localparam int AIW = 3*N+1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CW-1:0]         cand;
    logic [AIW-1:0]        a_init;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [XW-1:0]  x_sel;
    logic signed [YW-1:0]  y_sel;
    logic                  sel;
    logic                  out_valid;
    logic                  out_ready;
`ifdef SELECT_ERR_EN
    logic [8*N+23:0]       err_min;
`endif

    intersection_select_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .cand(cand), .a_init(a_init),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_sel(x_sel), .y_sel(y_sel), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef SELECT_ERR_EN
        , .err_min(err_min)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic signed [127:0] sx(input logic [255:0] v, input int w);
        logic signed [127:0] r;
        r = v[127:0];
        for (int i = w; i < 128; i++) r[i] = v[w-1];
        return r;
    endfunction

    // Reference: squared distance to A minus rA^2 in 128-bit integers; ties favour candidate 1.
    task automatic model(input logic [CW-1:0] c, input logic [AIW-1:0] a,
                         output logic [127:0] ex, output logic [127:0] ey,
                         output logic [127:0] es, output logic [127:0] ee);
        logic [255:0] cz, az;
        logic signed [127:0] x1, y1, x2, y2, xa, ya, ra, d1, d2, r1, r2;
        logic [127:0] mx, my;
        cz = 256'(c);
        az = 256'(a);
        x1 = sx(cz >> 104, 42);
        y1 = sx(cz >> 73, 31);
        x2 = sx(cz >> 31, 42);
        y2 = sx(cz, 31);
        xa = sx(az >> 17, 8);
        ya = sx(az >> 9, 8);
        ra = sx(az, 9);
        d1 = (x1 - xa) * (x1 - xa) + (y1 - ya) * (y1 - ya) - ra * ra;
        d2 = (x2 - xa) * (x2 - xa) + (y2 - ya) * (y2 - ya) - ra * ra;
        r1 = (d1 < 0) ? -d1 : d1;
        r2 = (d2 < 0) ? -d2 : d2;
        mx = (128'(1) << XW) - 1;
        my = (128'(1) << YW) - 1;
        if (r1 <= r2) begin
            ex = x1 & mx; ey = y1 & my; es = 128'(0); ee = r1;
        end else begin
            ex = x2 & mx; ey = y2 & my; es = 128'(1); ee = r2;
        end
    endtask

    function automatic logic [CW-1:0] pack(input logic [63:0] x1, input logic [63:0] y1,
                                           input logic [63:0] x2, input logic [63:0] y2);
        return {x1[41:0], y1[30:0], x2[41:0], y2[30:0]};
    endfunction

    function automatic logic [AIW-1:0] apack(input logic [63:0] xa, input logic [63:0] ya,
                                             input logic [63:0] ra);
        return {xa[7:0], ya[7:0], ra[8:0]};
    endfunction

    function automatic logic [63:0] rnd(input bit big);
        if (big) return {$urandom, $urandom};
        return 64'(int'($urandom_range(600, 0)) - 300);
    endfunction

    task automatic run_job(input string name, input logic [CW-1:0] c, input logic [AIW-1:0] a,
                           input int bp);
        logic [127:0] ex, ey, es, ee;
        int lat;
        bit got;
        model(c, a, ex, ey, es, ee);
        @(negedge clk);
        check({name, "_in_ready_idle"}, 128'(in_ready), 128'(1));
        cand      = c;
        a_init    = a;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            if (lat == 2) check({name, "_in_ready_busy"}, 128'(in_ready), 128'(0));
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) got = 1'b1;
        end
        check({name, "_latency"}, 128'(lat), 128'(6));
        check({name, "_x_sel"}, 128'($unsigned(x_sel)), ex);
        check({name, "_y_sel"}, 128'($unsigned(y_sel)), ey);
        check({name, "_sel"}, 128'(sel), es);
`ifdef SELECT_ERR_EN
        check({name, "_err_min"}, 128'(err_min), ee);
`endif
        for (int i = 0; i < bp; i++) begin
            in_valid = i[0];
            cand     = pack(rnd(1), rnd(1), rnd(1), rnd(1));
            a_init   = AIW'($urandom);
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, 128'(out_valid), 128'(1));
            check({name, "_hold_x"}, 128'($unsigned(x_sel)), ex);
            check({name, "_hold_y"}, 128'($unsigned(y_sel)), ey);
            check({name, "_hold_sel"}, 128'(sel), es);
            check({name, "_hold_in_ready"}, 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_done_valid"}, 128'(out_valid), 128'(0));
        check({name, "_done_in_ready"}, 128'(in_ready), 128'(1));
        check({name, "_keep_x"}, 128'($unsigned(x_sel)), ex);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] c;
        logic [AIW-1:0] a;
        bit big;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cand = '0; a_init = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_x_sel", 128'($unsigned(x_sel)), 128'(0));
        check("rst_y_sel", 128'($unsigned(y_sel)), 128'(0));
        check("rst_sel", 128'(sel), 128'(0));
`ifdef SELECT_ERR_EN
        check("rst_err_min", 128'(err_min), 128'(0));
`endif
        rst = 1'b0;

        run_job("t1", pack(64'(3), 64'(4), 64'(-3), 64'(4)), apack(64'(3), 64'(0), 64'(4)), 0);
        run_job("t2", pack(64'(-3), 64'(4), 64'(3), 64'(4)), apack(64'(3), 64'(0), 64'(4)), 0);
        run_job("t3_tie", pack(64'(3), 64'(4), 64'(4), 64'(3)), apack(64'(0), 64'(0), 64'(5)), 0);
        run_job("t4_bp", pack(64'(3), 64'(4), 64'(-3), 64'(4)), apack(64'(3), 64'(0), 64'(4)), 10);

        // Abort a job in flight during the third multiply step.
        @(negedge clk);
        cand     = pack(64'(-3), 64'(4), 64'(3), 64'(4));
        a_init   = apack(64'(3), 64'(0), 64'(4));
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 128'(out_valid), 128'(0));
        check("t5_rst_in_ready", 128'(in_ready), 128'(1));
        check("t5_rst_x_sel", 128'($unsigned(x_sel)), 128'(0));
        check("t5_rst_y_sel", 128'($unsigned(y_sel)), 128'(0));
        check("t5_rst_sel", 128'(sel), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("t5_no_out_valid", 128'(out_valid), 128'(0));
        end
        run_job("t5_after", pack(64'(-3), 64'(4), 64'(3), 64'(4)), apack(64'(3), 64'(0), 64'(4)), 0);

        run_job("t6_neg", pack(64'(-128), 64'(-128), 64'(127), 64'(127)),
                apack(64'(-128), 64'(-128), 64'(0)), 0);

        for (int j = 0; j < 40; j++) begin
            big = ($urandom_range(3, 0) == 0);
            c = pack(rnd(big), rnd(big), rnd(big), rnd(big));
            a = AIW'($urandom);
            run_job("rand", c, a, int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
